pri_scan_encoder: RTL and testbench

PRI_SCAN_ENCODER -- requirements
Module: pri_scan_encoder

---
 rtl/pri_enc_pkg.sv | 26 ++
 rtl/pri_find_msb.sv | 26 ++
 rtl/pri_scan_encoder.sv | 109 ++++++++++
 tb/tb_pri_scan_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pri_enc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pri_enc_pkg : shared FSM state encoding and index coding function   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pri_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Wide enough for any legal index (N <= 64); callers truncate to their W.
  localparam int MAX_IDX_W = 7;

  function automatic logic [MAX_IDX_W-1:0] code_index(
    input logic [MAX_IDX_W-1:0] idx,
    input logic [MAX_IDX_W-1:0] max_idx,
    input logic                 inv
  );
    return inv ? (max_idx - idx) : idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pri_find_msb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pri_find_msb : combinational highest-set-bit search with any flag   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pri_find_msb #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Ascending scan: the last hit, i.e. the highest set bit, wins.
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (i_vec[k]) o_idx = W'(k);
    end
  end

  assign o_any = |i_vec;

endmodule
`default_nettype wire

// File: rtl/pri_scan_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pri_scan_encoder : captured priority encoder streaming indices      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pri_scan_encoder
  import pri_enc_pkg::*;
#(
  parameter int N       = 16,
  parameter int W       = $clog2(N),
  parameter int INV_OUT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ei_n,
  input  logic [N-1:0] i_n,
  input  logic         load,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] z,
  output logic         gs_n,
  output logic         eo_n,
  output logic         done,
  output logic [W:0]   cnt
);

  localparam logic [W:0] C_CNT_MAX = (W+1)'(N);

  state_e       r_state;
  logic [N-1:0] r_pend;
  logic [W:0]   r_cnt;
  logic         r_eo_n;
  logic         r_done;
  logic         r_gs_n;

  logic [W-1:0] w_idx;
  logic         w_any;
  logic [N-1:0] w_pend_clr;
  logic         w_last;
  logic [N-1:0] w_req;

  pri_find_msb #(.N(N), .W(W)) u_find (
    .i_vec (r_pend),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_req      = ~i_n;
  assign w_pend_clr = r_pend & ~({{(N-1){1'b0}}, 1'b1} << w_idx);
  assign w_last     = ~|w_pend_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_eo_n  <= 1'b1;
      r_done  <= 1'b0;
      r_gs_n  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!ei_n && load) begin
            r_pend <= w_req;
            r_cnt  <= '0;
            if (|w_req) begin
              r_state <= ST_SCAN;
              r_gs_n  <= 1'b0;
              r_eo_n  <= 1'b1;
            end else begin
              r_eo_n  <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          // Abort outranks a handshake in the same cycle.
          if (ei_n) begin
            r_pend  <= '0;
            r_state <= ST_IDLE;
            r_gs_n  <= 1'b1;
          end else if (out_ready) begin
            r_pend <= w_pend_clr;
            if (r_cnt != C_CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= ST_DONE;
              r_gs_n  <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_gs_n  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = (r_state == ST_SCAN) && w_any;
  assign z         = W'(code_index(MAX_IDX_W'(w_idx), MAX_IDX_W'(N - 1), INV_OUT != 0));
  assign gs_n      = r_gs_n;
  assign eo_n      = r_eo_n;
  assign done      = r_done;
  assign cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pri_scan_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pri_scan_encoder : table + scoreboard bench, INV_OUT=0 and =1    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pri_scan_encoder;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ei_n;
  logic [N-1:0] i_n;
  logic         load;
  logic         out_ready;

  logic         out_valid0, gs_n0, eo_n0, done0;
  logic [W-1:0] z0;
  logic [W:0]   cnt0;
  logic         out_valid1, gs_n1, eo_n1, done1;
  logic [W-1:0] z1;
  logic [W:0]   cnt1;

  int n_cmp = 0;
  int n_err = 0;
  int q_exp[$];

  typedef struct {
    logic [N-1:0] vec;
    int           mode;   // 0: always ready, 1: ready pattern 1,0,0
    int           exp_n;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  pri_scan_encoder #(.N(N), .INV_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ei_n(ei_n), .i_n(i_n), .load(load),
    .out_ready(out_ready), .out_valid(out_valid0), .z(z0), .gs_n(gs_n0),
    .eo_n(eo_n0), .done(done0), .cnt(cnt0)
  );

  pri_scan_encoder #(.N(N), .INV_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ei_n(ei_n), .i_n(i_n), .load(load),
    .out_ready(out_ready), .out_valid(out_valid1), .z(z1), .gs_n(gs_n1),
    .eo_n(eo_n1), .done(done1), .cnt(cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_scan(input logic [N-1:0] vec, input int mode, input int exp_n);
    int         cyc;
    logic       rdy;
    logic       hold;
    logic [W-1:0] hold_z;
    int         e;
    cyc  = 0;
    hold = 1'b0;
    hold_z = '0;
    @(negedge clk);
    ei_n = 1'b0; load = 1'b1; i_n = vec; out_ready = 1'b0;
    for (int b = N - 1; b >= 0; b--) if (!vec[b]) q_exp.push_back(b);
    chk("model_count", 32'(q_exp.size()), 32'(exp_n));
    @(negedge clk);
    load = 1'b0; i_n = '1;
    chk("latency_valid", 32'(out_valid0), 32'(exp_n != 0));
    if (exp_n == 0) begin
      chk("empty_eo_n", 32'(eo_n0), 0);
      chk("empty_gs_n", 32'(gs_n0), 1);
      @(negedge clk);
      chk("empty_no_done", 32'(done0), 0);
      chk("empty_valid", 32'(out_valid0), 0);
      return;
    end
    while (cyc < 100) begin
      if (q_exp.size() == 0) begin
        load = 1'b0;
        chk("valid_done", 32'(out_valid0), 0);
        chk("gs_n_done", 32'(gs_n0), 1);
        chk("done_pulse", 32'(done0), 1);
        break;
      end
      chk("valid_scan", 32'(out_valid0), 1);
      chk("gs_n_scan", 32'(gs_n0), 0);
      chk("gs_n_scan_inv", 32'(gs_n1), 0);
      chk("done_scan", 32'(done0), 0);
      if (hold) chk("z_stable", 32'(z0), 32'(hold_z));
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      out_ready = rdy;
      // Loads during a scan must have no effect.
      load = cyc[0];
      i_n  = N'($urandom);
      if (rdy) begin
        e = q_exp.pop_front();
        chk("z_bin", 32'(z0), 32'(e));
        chk("z_inv", 32'(z1), 32'(N - 1 - e));
        hold = 1'b0;
      end else begin
        hold   = 1'b1;
        hold_z = z0;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL scan_timeout: got %0d cycles expected done", cyc);
      q_exp.delete();
    end
    out_ready = 1'b0; i_n = '1;
    @(negedge clk);
    chk("done_one_cycle", 32'(done0), 0);
    chk("cnt_final", 32'(cnt0), 32'(exp_n));
    chk("cnt_final_inv", 32'(cnt1), 32'(exp_n));
    chk("eo_n_nonzero", 32'(eo_n0), 1);
  endtask

  initial begin
    tbl[0] = '{vec: 16'h7FFE, mode: 0, exp_n: 2};
    tbl[1] = '{vec: 16'hFF7F, mode: 0, exp_n: 1};
    tbl[2] = '{vec: 16'h0000, mode: 1, exp_n: 16};
    tbl[3] = '{vec: 16'hFFFF, mode: 0, exp_n: 0};
    tbl[4] = '{vec: 16'hA5C3, mode: 1, exp_n: 8};
    tbl[5] = '{vec: 16'hFFFE, mode: 1, exp_n: 1};

    rst_n = 1'b0; ei_n = 1'b1; load = 1'b0; i_n = '1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid0), 0);
    chk("rst_gs_n", 32'(gs_n0), 1);
    chk("rst_eo_n", 32'(eo_n0), 1);
    chk("rst_done", 32'(done0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_z", 32'(z0), 0);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) run_scan(tbl[t].vec, tbl[t].mode, tbl[t].exp_n);

    // Explicit beat timing for the INV_OUT=1 single-request case.
    @(negedge clk);
    ei_n = 1'b0; load = 1'b1; i_n = 16'hFF7F; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0; i_n = '1;
    chk("single_z_inv", 32'(z1), 8);
    chk("single_gs_n", 32'(gs_n1), 0);
    @(negedge clk);
    chk("single_done", 32'(done1), 1);
    chk("single_gs_n_after", 32'(gs_n1), 1);
    out_ready = 1'b0;

    // Abort after two acceptances of a four-request scan.
    @(negedge clk);
    ei_n = 1'b0; load = 1'b1; i_n = ~16'h8421; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0; i_n = '1;
    chk("abort_z0", 32'(z0), 15);
    @(negedge clk);
    chk("abort_z1", 32'(z0), 10);
    @(negedge clk);
    chk("abort_z2", 32'(z0), 5);
    ei_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid0), 0);
    chk("abort_gs_n", 32'(gs_n0), 1);
    chk("abort_no_done", 32'(done0), 0);
    chk("abort_cnt", 32'(cnt0), 2);
    @(negedge clk);
    chk("abort_no_done_late", 32'(done0), 0);
    run_scan(~16'h0003, 0, 2);

    // eo_n stays low across idle cycles and ignored loads.
    run_scan(16'hFFFF, 0, 0);
    ei_n = 1'b1; load = 1'b1; i_n = 16'h0000;
    repeat (3) @(negedge clk);
    chk("eo_n_hold", 32'(eo_n0), 0);
    chk("ignored_load_valid", 32'(out_valid0), 0);
    load = 1'b0;
    run_scan(~16'h0010, 0, 1);

    // Reset mid-scan, with a load asserted on the same edge.
    @(negedge clk);
    ei_n = 1'b0; load = 1'b1; i_n = 16'h00FF; out_ready = 1'b0;
    @(negedge clk);
    load = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_cnt", 32'(cnt0), 1);
    rst_n = 1'b0; load = 1'b1; i_n = 16'h0000;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid0), 0);
    chk("mid_rst_gs_n", 32'(gs_n0), 1);
    chk("mid_rst_eo_n", 32'(eo_n0), 1);
    chk("mid_rst_done", 32'(done0), 0);
    chk("mid_rst_cnt", 32'(cnt0), 0);
    chk("mid_rst_z", 32'(z0), 0);
    rst_n = 1'b1; ei_n = 1'b1; load = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("dis_load_valid", 32'(out_valid0), 0);
    chk("dis_load_gs_n", 32'(gs_n0), 1);
    chk("dis_load_eo_n", 32'(eo_n0), 1);
    load = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
